// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and MEM-stage data ports onto one shared memory port.
// A grant is issued only from IDLE, and grants alternate between the ports when both are requesting.
module mem_port_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ_EN,
  input  logic [31:0] I_ADDRESS,
  output logic [31:0] I_READDATA,
  output logic        I_BUSYWAIT,
  input  logic        D_READ_EN,
  input  logic        D_WRITE_EN,
  input  logic [31:0] D_ADDRESS,
  input  logic [31:0] D_WRITEDATA,
  output logic [31:0] D_READDATA,
  output logic        D_BUSYWAIT,
  output logic        M_READ,
  output logic        M_WRITE,
  output logic [31:0] M_ADDRESS,
  output logic [31:0] M_WRITEDATA,
  input  logic [31:0] M_READDATA,
  input  logic        M_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        isWrite_q, isWrite_d;
  logic        lastGntD_q, lastGntD_d;
  logic        dDone_q, dDone_d;
  logic        iDone_q, iDone_d;
  logic [31:0] dRdata_q, dRdata_d;
  logic [31:0] iRdata_q, iRdata_d;

  logic dReqEn, dPending, iPending;
  logic grantD, grantI, complete;

  assign dReqEn   = D_READ_EN | D_WRITE_EN;
  assign dPending = dReqEn & ~dDone_q;
  assign iPending = I_READ_EN & ~iDone_q;

  // With both pending, D wins unless it was the last port granted.
  assign grantD   = (state_q == IDLE) & dPending & (~iPending | ~lastGntD_q);
  assign grantI   = (state_q == IDLE) & iPending & ~grantD;
  assign complete = (state_q != IDLE) & ~M_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grantD)      state_d = SERVE_D;
        else if (grantI) state_d = SERVE_I;
      end
      SERVE_D, SERVE_I: begin
        if (!M_BUSYWAIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_READ  = 1'b0;
    M_WRITE = 1'b0;
    case (state_q)
      SERVE_I: M_READ = 1'b1;
      SERVE_D: begin
        M_READ  = ~isWrite_q;
        M_WRITE = isWrite_q;
      end
      default: ;
    endcase
  end

  assign M_ADDRESS   = addr_q;
  assign M_WRITEDATA = wdata_q;
  assign I_READDATA  = iRdata_q;
  assign D_READDATA  = dRdata_q;
  assign I_BUSYWAIT  = I_READ_EN & ~iDone_q;
  assign D_BUSYWAIT  = dReqEn & ~dDone_q;

  // Request capture on grant; completion raises done only if the requester is still asking.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    isWrite_d  = isWrite_q;
    lastGntD_d = lastGntD_q;
    dDone_d    = 1'b0;
    iDone_d    = 1'b0;
    dRdata_d   = dRdata_q;
    iRdata_d   = iRdata_q;
    if (grantD) begin
      addr_d     = D_ADDRESS;
      wdata_d    = D_WRITEDATA;
      isWrite_d  = D_WRITE_EN;
      lastGntD_d = 1'b1;
    end else if (grantI) begin
      addr_d     = I_ADDRESS;
      wdata_d    = 32'h0;
      isWrite_d  = 1'b0;
      lastGntD_d = 1'b0;
    end
    if (complete && state_q == SERVE_D && dReqEn) begin
      dDone_d = 1'b1;
      if (!isWrite_q) dRdata_d = M_READDATA;
    end
    if (complete && state_q == SERVE_I && I_READ_EN) begin
      iDone_d  = 1'b1;
      iRdata_d = M_READDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      isWrite_q  <= 1'b0;
      lastGntD_q <= 1'b0;
      dDone_q    <= 1'b0;
      iDone_q    <= 1'b0;
      dRdata_q   <= 32'h0;
      iRdata_q   <= 32'h0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      isWrite_q  <= isWrite_d;
      lastGntD_q <= lastGntD_d;
      dDone_q    <= dDone_d;
      iDone_q    <= iDone_d;
      dRdata_q   <= dRdata_d;
      iRdata_q   <= iRdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table followed by
// hand-written sequences for stalls, alternation, reset abort and flush.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        iReadEn;
  logic [31:0] iAddress;
  logic [31:0] iReaddata;
  logic        iBusywait;
  logic        dReadEn;
  logic        dWriteEn;
  logic [31:0] dAddress;
  logic [31:0] dWritedata;
  logic [31:0] dReaddata;
  logic        dBusywait;
  logic        mRead;
  logic        mWrite;
  logic [31:0] mAddress;
  logic [31:0] mWritedata;
  logic [31:0] mReaddata;
  logic        mBusywait;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .CLK         (clk),
    .RESET       (rst),
    .I_READ_EN   (iReadEn),
    .I_ADDRESS   (iAddress),
    .I_READDATA  (iReaddata),
    .I_BUSYWAIT  (iBusywait),
    .D_READ_EN   (dReadEn),
    .D_WRITE_EN  (dWriteEn),
    .D_ADDRESS   (dAddress),
    .D_WRITEDATA (dWritedata),
    .D_READDATA  (dReaddata),
    .D_BUSYWAIT  (dBusywait),
    .M_READ      (mRead),
    .M_WRITE     (mWrite),
    .M_ADDRESS   (mAddress),
    .M_WRITEDATA (mWritedata),
    .M_READDATA  (mReaddata),
    .M_BUSYWAIT  (mBusywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iEn;
    logic [31:0] iAddr;
    logic        dRd;
    logic        dWr;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        mBusy;
    logic [31:0] mRdata;
    logic        eMRead;
    logic        eMWrite;
    logic        chkMem;
    logic [31:0] eMAddr;
    logic [31:0] eMWdata;
    logic        eIBusy;
    logic [31:0] eIRdata;
    logic        eDBusy;
    logic [31:0] eDRdata;
  } vec_t;

  vec_t vecs [12];

  // Drives one cycle's inputs shortly after the rising edge, then lets combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic ie, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic mb, input logic [31:0] mrd);
    @(posedge clk);
    #1;
    rst        = r;
    iReadEn    = ie;
    iAddress   = ia;
    dReadEn    = dr;
    dWriteEn   = dw;
    dAddress   = da;
    dWritedata = dwd;
    mBusywait  = mb;
    mReaddata  = mrd;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic isD;
    logic odd;

    // rst iEn iAddr dRd dWr dAddr dWdata mBusy mRdata | eMRd eMWr chk eMAddr eMWdata eIBusy eIRdata eDBusy eDRdata
    vecs[0]  = '{1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                 1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF,
                 1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF,
                 1'b1, 1'b0, 1'b1, 32'h100, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF,
                 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF,
                 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'hCAFEF00D,
                 1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'hCAFEF00D,
                 1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 1'b1, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'hCAFEF00D,
                 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h200, 32'h12345678, 1'b0, 32'hCAFEF00D,
                 1'b1, 1'b0, 1'b1, 32'h300, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h200, 32'h12345678, 1'b0, 32'hCAFEF00D,
                 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 32'h200, 32'h0,        1'b0, 32'hCAFEF00D,
                 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 32'h0};

    rst = 1'b1; iReadEn = 1'b0; iAddress = '0; dReadEn = 1'b0; dWriteEn = 1'b0;
    dAddress = '0; dWritedata = '0; mBusywait = 1'b0; mReaddata = '0;
    repeat (2) @(posedge clk);

    // Table: reset state, single fetch, both-requesting D-first, then I.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].iEn, vecs[i].iAddr, vecs[i].dRd, vecs[i].dWr,
                    vecs[i].dAddr, vecs[i].dWdata, vecs[i].mBusy, vecs[i].mRdata);
      checkOutput($sformatf("v%0d M_READ", i), {31'b0, mRead}, {31'b0, vecs[i].eMRead});
      checkOutput($sformatf("v%0d M_WRITE", i), {31'b0, mWrite}, {31'b0, vecs[i].eMWrite});
      if (vecs[i].chkMem) begin
        checkOutput($sformatf("v%0d M_ADDRESS", i), mAddress, vecs[i].eMAddr);
        checkOutput($sformatf("v%0d M_WRITEDATA", i), mWritedata, vecs[i].eMWdata);
      end
      checkOutput($sformatf("v%0d I_BUSYWAIT", i), {31'b0, iBusywait}, {31'b0, vecs[i].eIBusy});
      checkOutput($sformatf("v%0d I_READDATA", i), iReaddata, vecs[i].eIRdata);
      checkOutput($sformatf("v%0d D_BUSYWAIT", i), {31'b0, dBusywait}, {31'b0, vecs[i].eDBusy});
      checkOutput($sformatf("v%0d D_READDATA", i), dReaddata, vecs[i].eDRdata);
    end

    // D load stalled three cycles by memory busywait.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h11111111);
    checkOutput("stall idle M_READ", {31'b0, mRead}, 32'd0);
    checkOutput("stall idle D_BUSYWAIT", {31'b0, dBusywait}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h22222222);
      checkOutput($sformatf("stall%0d M_READ", k), {31'b0, mRead}, 32'd1);
      checkOutput($sformatf("stall%0d M_WRITE", k), {31'b0, mWrite}, 32'd0);
      checkOutput($sformatf("stall%0d M_ADDRESS", k), mAddress, 32'h40);
      checkOutput($sformatf("stall%0d D_BUSYWAIT", k), {31'b0, dBusywait}, 32'd1);
      checkOutput($sformatf("stall%0d D_READDATA", k), dReaddata, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h55AA55AA);
    checkOutput("stall last M_READ", {31'b0, mRead}, 32'd1);
    checkOutput("stall last D_BUSYWAIT", {31'b0, dBusywait}, 32'd1);
    checkOutput("stall last D_READDATA", dReaddata, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    checkOutput("stall done D_BUSYWAIT", {31'b0, dBusywait}, 32'd0);
    checkOutput("stall done D_READDATA", dReaddata, 32'h55AA55AA);
    checkOutput("stall done M_READ", {31'b0, mRead}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("stall hold D_READDATA", dReaddata, 32'h55AA55AA);

    // Both requesting continuously; D was granted last, so I goes first, then alternate.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b1, 32'hA00, 1'b0, 1'b1, 32'hD00, 32'h0BADCAFE, 1'b0, 32'h13579BDF);
      odd = (c % 2) == 1;
      isD = ((c / 2) % 2) == 1;
      checkOutput($sformatf("alt%0d M_READ", c), {31'b0, mRead}, {31'b0, odd & ~isD});
      checkOutput($sformatf("alt%0d M_WRITE", c), {31'b0, mWrite}, {31'b0, odd & isD});
      if (odd) checkOutput($sformatf("alt%0d M_ADDRESS", c), mAddress, isD ? 32'hD00 : 32'hA00);
      checkOutput($sformatf("alt%0d I_BUSYWAIT", c), {31'b0, iBusywait}, {31'b0, ~(c == 2 || c == 6)});
      checkOutput($sformatf("alt%0d D_BUSYWAIT", c), {31'b0, dBusywait}, {31'b0, ~(c == 4)});
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("alt end M_READ", {31'b0, mRead}, 32'd0);
    checkOutput("alt end I_READDATA", iReaddata, 32'h13579BDF);

    // Reset arriving while SERVE_I is stalled aborts the access.
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("rst c0 M_READ", {31'b0, mRead}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("rst c1 M_READ", {31'b0, mRead}, 32'd1);
    checkOutput("rst c1 M_ADDRESS", mAddress, 32'h500);
    applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h77777777);
    checkOutput("rst c2 M_READ", {31'b0, mRead}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    checkOutput("rst c3 M_READ", {31'b0, mRead}, 32'd0);
    checkOutput("rst c3 M_WRITE", {31'b0, mWrite}, 32'd0);
    checkOutput("rst c3 I_BUSYWAIT", {31'b0, iBusywait}, 32'd1);
    checkOutput("rst c3 I_READDATA", iReaddata, 32'h0);
    checkOutput("rst c3 D_READDATA", dReaddata, 32'h0);
    checkOutput("rst c3 M_ADDRESS", mAddress, 32'h0);

    // Fetch flushed mid-access: completes silently, later fetch behaves normally.
    applyStimulus(1'b0, 1'b0, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h99999999);
    checkOutput("flush c4 M_READ", {31'b0, mRead}, 32'd1);
    checkOutput("flush c4 M_ADDRESS", mAddress, 32'h500);
    checkOutput("flush c4 I_BUSYWAIT", {31'b0, iBusywait}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hABCD0123);
    checkOutput("flush c5 M_READ", {31'b0, mRead}, 32'd0);
    checkOutput("flush c5 I_BUSYWAIT", {31'b0, iBusywait}, 32'd1);
    checkOutput("flush c5 I_READDATA", iReaddata, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hABCD0123);
    checkOutput("flush c6 M_READ", {31'b0, mRead}, 32'd1);
    checkOutput("flush c6 M_ADDRESS", mAddress, 32'h600);
    checkOutput("flush c6 I_BUSYWAIT", {31'b0, iBusywait}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hABCD0123);
    checkOutput("flush c7 I_BUSYWAIT", {31'b0, iBusywait}, 32'd0);
    checkOutput("flush c7 I_READDATA", iReaddata, 32'hABCD0123);
    checkOutput("flush c7 M_READ", {31'b0, mRead}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset, sampled on rising CLK edge.
REQ-003 SHALL have ports I_READ_EN input 1, I_ADDRESS input 32: instruction-fetch read request and word address.
REQ-004 SHALL have ports I_READDATA output 32, I_BUSYWAIT output 1: fetch data and fetch stall.
REQ-005 SHALL have ports D_READ_EN input 1, D_WRITE_EN input 1, D_ADDRESS input 32, D_WRITEDATA input 32: MEM-stage data request.
REQ-006 SHALL have ports D_READDATA output 32, D_BUSYWAIT output 1: load data and MEM-stage stall.
REQ-007 SHALL have ports M_READ output 1, M_WRITE output 1, M_ADDRESS output 32, M_WRITEDATA output 32: shared unified-memory request.
REQ-008 SHALL have ports M_READDATA input 32, M_BUSYWAIT input 1: shared memory response; M_BUSYWAIT low while M_READ/M_WRITE high means access completes at that edge.

Function
REQ-009 SHALL implement FSM states IDLE, SERVE_D, SERVE_I.
REQ-010 SHALL latch address, write data and read/write type into internal registers on grant; M_* outputs driven only from latched values.
REQ-011 SHALL drive M_READ=M_WRITE=0 in IDLE; in SERVE_I: M_READ=1, M_WRITE=0; in SERVE_D: exactly one of M_READ/M_WRITE=1 per latched type.
REQ-012 SHALL treat a requester as pending when its enable is high and its done flag (REQ-016) is low.
REQ-013 SHALL grant from IDLE only: one pending -> serve it; both pending -> serve the one not granted last (LAST_GNT flag), D wins if LAST_GNT is reset value.
REQ-014 SHALL update LAST_GNT on each grant; no grant issued from SERVE states.
REQ-015 SHALL, in SERVE_x, stay while M_BUSYWAIT=1; on edge with M_BUSYWAIT=0 go to IDLE.
REQ-016 SHALL on completion set one-cycle done flag D_DONE/I_DONE and register M_READDATA into D_READDATA (reads only) or I_READDATA; done flag clears on next edge.
REQ-017 SHALL drive x_BUSYWAIT = x request enable AND NOT x_DONE (combinational); readdata valid in the done cycle and held until next completion for that port.
REQ-018 SHALL, with zero-wait memory, give latency: request seen cycle 0 (IDLE), SERVE cycle 1, done/busywait low cycle 2.
REQ-019 SHALL treat D_READ_EN=D_WRITE_EN=1 as a write.
REQ-020 SHALL complete an in-flight access even if its request enable drops; done flag then not set, readdata register not updated.
REQ-021 SHALL ignore D_WRITEDATA/addresses changing during SERVE (latched values used).
REQ-022 SHALL not alter D_READDATA on write completion.

Reset
REQ-023 SHALL on RESET=1 go to IDLE, clear done flags, LAST_GNT=D-last-not (D priority), I_READDATA=D_READDATA=0, latched regs=0.
REQ-024 SHALL, with RESET asserted mid-SERVE, drive M_READ=M_WRITE=0 from the next cycle; the aborted access produces no done flag.
REQ-025 SHALL give busywait outputs after reset equal to the request enables (done flags 0).

Verification
REQ-026 SHALL verify: zero-wait memory, I_READ_EN=1 I_ADDRESS=0x100, M_READDATA=0xDEADBEEF -> M_READ=1 M_ADDRESS=0x100 cycle 1, I_BUSYWAIT=0 and I_READDATA=0xDEADBEEF cycle 2.
REQ-027 SHALL verify: both requests after reset, D write 0x200/0x12345678 -> D served first (M_WRITE=1, M_WRITEDATA=0x12345678), then I served; I_BUSYWAIT high until its own done.
REQ-028 SHALL verify: M_BUSYWAIT held high 3 cycles in SERVE_D load -> state held, D_BUSYWAIT=1 throughout, D_READDATA updated only on completion edge.
REQ-029 SHALL verify: both continuously requesting -> grants alternate D,I,D,I; neither starves.
REQ-030 SHALL verify: RESET=1 during SERVE_I -> next cycle M_READ=0, state IDLE, I_READDATA=0, no done pulse.
REQ-031 SHALL verify: I_READ_EN dropped mid-SERVE_I (flush) -> access completes, I_READDATA unchanged, next grant proceeds normally.
